out_dac_serializer: RTL and testbench
=====================================

OUT_DAC_SERIALIZER -- requirements
Module: out_dac_serializer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set FIFO entries; power of 2, at least 2.
REQ-002 Parameter DIV, default 2, SHALL set the dac_sclk half-period in CLK cycles; at least 1.
REQ-003 CLK  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  10  sample stream from the core OUT[9:0] bus.
REQ-006 en  input  1  capture enable.
REQ-007 clr_ovf  input  1  clears the overflow flag.
REQ-008 dac_sclk  output  1  serial clock to the external DAC, idle low.
REQ-009 dac_cs_n  output  1  frame select, active low.
REQ-010 dac_mosi  output  1  serial data, MSB first.
REQ-011 busy  output  1  high whenever the TX FSM is not in IDLE.
REQ-012 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 overflow  output  1  sticky flag for a dropped sample.

Function
REQ-014 Change detect: on a CLK edge with en=1, a push SHALL occur when last_valid=0 or din!=last.
- On every detected change, last<=din and last_valid<=1, whether or not the push is accepted.
REQ-015 Push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle (level unchanged).
- Otherwise the sample SHALL be dropped and overflow<=1.
REQ-016 overflow SHALL be cleared by clr_ovf=1; a new drop in the same cycle wins (overflow stays 1).
REQ-017 With en=0 there SHALL be no pushes; last/last_valid SHALL hold.
REQ-018 TX FSM states SHALL be IDLE, SHIFT and GAP.
REQ-019 IDLE: while fifo_level!=0, pop the head, load shreg={2'b01,data}, and go to SHIFT.
- Registered outputs: dac_cs_n=0, dac_mosi=shreg[11].
REQ-020 SHIFT: dac_sclk SHALL toggle every DIV cycles, starting DIV cycles after dac_cs_n falls.
- dac_mosi SHALL change only on falling sclk edges (DAC samples on rising edges).
- Exactly 12 rising edges per frame.
REQ-021 After the 12th falling sclk edge: dac_cs_n<=1 and dac_sclk low, mosi<=0, go to GAP.
- Frame length with dac_cs_n low SHALL be exactly 24*DIV CLK cycles.
REQ-022 GAP SHALL hold dac_cs_n=1 for 2*DIV cycles, then return to IDLE.
- A non-empty FIFO SHALL start the next frame on the following cycle.
REQ-023 Latency: din change sampled at edge t0 SHALL produce dac_cs_n low at edge t0+2 when the FSM is IDLE.
REQ-024 Back-to-back frames SHALL be separated only by GAP+1 cycles; no sample reordering.
REQ-025 fifo_level SHALL be exact on every cycle, including simultaneous push and pop.

Reset
REQ-026 On reset=1, asynchronously: dac_cs_n=1, dac_sclk=0, dac_mosi=0, busy=0, fifo_level=0, overflow=0, last_valid=0, state=IDLE.
REQ-027 Reset mid-frame SHALL abort the frame immediately (cs_n high with no further sclk edges) and discard FIFO contents.
REQ-028 The first din after reset release with en=1 SHALL always be captured.

Structure
REQ-029 Package out_dac_pkg SHALL hold FRAME_W=12, HDR=2'b01, DATA_W=10 and the TX state enum.
REQ-030 The FIFO SHALL be a separate sub-module out_dac_fifo: synchronous, full/empty/level outputs, async active-high reset.
REQ-031 The total implementation SHALL be 120-400 lines of RTL, with no latches and no gated clocks.

Verification
REQ-032 Reset held 100 ns, then en=1 and din=10'h2A5 -> one frame, MOSI bits 01_1010100101, cs_n low 48 cycles (DIV=2).
REQ-033 din constant at 10'h155 for 200 cycles -> exactly one frame; fifo_level returns to 0.
REQ-034 din changes every cycle for 8 cycles (0x001..0x008), DEPTH=4, during the first frame -> frames 0x001..0x005 sent in order.
- overflow=1 and stays set until clr_ovf pulse.
- clr_ovf asserted in the same cycle as a drop -> overflow remains 1.
REQ-035 reset asserted at the 6th sclk rising edge of a frame -> cs_n=1 and sclk=0 within the same cycle; no further frames.
- After release, din=10'h3FF is captured and sent.
REQ-036 Push and pop in the same cycle while full -> level unchanged, no overflow, data order preserved (scoreboard compares every decoded frame to the pushed sequence).

Source files
------------

// File: rtl/out_dac_pkg.sv
// Shared constants and TX state encoding for the 10-bit DAC output serializer.
package out_dac_pkg;

  localparam int         DATA_W     = 10;
  localparam int         FRAME_W    = 12;
  localparam logic [1:0] HDR        = 2'b01;
  // Half sclk periods per frame: one rising and one falling edge per bit.
  localparam int         HALF_EDGES = 2 * FRAME_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_t;

endpackage

// File: rtl/out_dac_fifo.sv
// Synchronous show-ahead FIFO; accepts a write while full when a read happens in the same cycle.
module out_dac_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/out_dac_serializer.sv
// Captures changes on the core OUT bus into a FIFO and streams each sample to an
// external SPI-style DAC as a 12-bit frame {HDR, data}, MSB first, mode-0 timing.
module out_dac_serializer
  import out_dac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DIV   = 2
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      din,
  input  logic                   en,
  input  logic                   clr_ovf,
  output logic                   dac_sclk,
  output logic                   dac_cs_n,
  output logic                   dac_mosi,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int CW = $clog2(2 * DIV);
  localparam int HW = $clog2(HALF_EDGES);

  tx_state_t          state, state_n;
  logic [DATA_W-1:0]  last;
  logic               last_valid;
  logic               chg;
  logic               drop;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  head;
  logic [FRAME_W-1:0] shreg, shreg_n;
  logic [CW-1:0]      div_cnt, div_n;
  logic [HW-1:0]      hcnt, hcnt_n;
  logic               cs_n_q, cs_n_n;
  logic               sclk_q, sclk_n;
  logic               mosi_q, mosi_n;

  assign chg  = en && (!last_valid || (din != last));
  assign drop = chg && fifo_full && !pop;

  out_dac_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (reset),
    .push  (chg),
    .wdata (din),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Change-detect validity and sticky overflow; a drop outranks a clear in the same cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      last_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (chg) last_valid <= 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Last seen sample; updated on every detected change even if the FIFO drops it.
  always_ff @(posedge CLK) begin
    if (chg) last <= din;
  end

  // TX next-state and output logic. The first SHIFT cycle is recognised by cs_n
  // still being high: it drops cs_n and presents the MSB, giving the two-cycle
  // capture-to-select latency while keeping cs_n low for exactly 24*DIV cycles.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    div_n   = div_cnt;
    hcnt_n  = hcnt;
    cs_n_n  = cs_n_q;
    sclk_n  = sclk_q;
    mosi_n  = mosi_q;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = {HDR, head};
          div_n   = '0;
          hcnt_n  = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_n_q) begin
          cs_n_n = 1'b0;
          mosi_n = shreg[FRAME_W-1];
          div_n  = '0;
        end else if (div_cnt == CW'(DIV - 1)) begin
          div_n  = '0;
          hcnt_n = hcnt + 1'b1;
          if (!sclk_q) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            if (hcnt == HW'(HALF_EDGES - 1)) begin
              cs_n_n  = 1'b1;
              mosi_n  = 1'b0;
              state_n = GAP;
            end else begin
              shreg_n = shreg << 1;
              mosi_n  = shreg[FRAME_W-2];
            end
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      GAP: begin
        if (div_cnt == CW'(2 * DIV - 1)) begin
          div_n   = '0;
          state_n = IDLE;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // TX control and pin registers; reset aborts any frame with cs_n high and sclk low.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      hcnt    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      hcnt    <= hcnt_n;
      cs_n_q  <= cs_n_n;
      sclk_q  <= sclk_n;
      mosi_q  <= mosi_n;
    end
  end

  // Frame shift register; always loaded before use, so no reset.
  always_ff @(posedge CLK) begin
    shreg <= shreg_n;
  end

  assign dac_cs_n = cs_n_q;
  assign dac_sclk = sclk_q;
  assign dac_mosi = mosi_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_out_dac_serializer.sv
// Directed bench for out_dac_serializer: a pin-level decoder rebuilds frames from
// cs_n/sclk/mosi and the main sequence compares them to hand-computed values.
module tb_out_dac_serializer;

  localparam int DEPTH = 4;
  localparam int DIV   = 2;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [9:0] din = '0;
  logic       dac_sclk, dac_cs_n, dac_mosi, busy, overflow;
  logic [2:0] fifo_level;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Decoded frames
  logic [11:0] fr_data [$];
  int          fr_low  [$];
  int          fr_rise [$];
  int          fr_start[$];
  int          fr_end  [$];
  int          viol  = 0;
  int          extra = 0;

  logic        p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, in_frame = 1'b0;
  logic [11:0] bits = '0;
  int          nrise = 0, nlow = 0, t_start = 0;

  out_dac_serializer #(.DEPTH(DEPTH), .DIV(DIV)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .din        (din),
    .en         (en),
    .clr_ovf    (clr_ovf),
    .dac_sclk   (dac_sclk),
    .dac_cs_n   (dac_cs_n),
    .dac_mosi   (dac_mosi),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pin-level decoder sampled mid-cycle
  always @(negedge CLK) begin
    if (reset) begin
      in_frame = 1'b0;
      p_cs     = 1'b1;
      p_sclk   = 1'b0;
      p_mosi   = 1'b0;
    end else begin
      if (!dac_cs_n) begin
        if (p_cs) begin
          in_frame = 1'b1;
          bits     = '0;
          nrise    = 0;
          nlow     = 0;
          t_start  = cyc;
        end
        nlow++;
        if (!p_sclk && dac_sclk) begin
          bits = {bits[10:0], dac_mosi};
          nrise++;
        end
        if (!p_cs && (dac_mosi !== p_mosi) && !(p_sclk && !dac_sclk)) viol++;
      end else begin
        if (!p_cs && in_frame) begin
          fr_data.push_back(bits);
          fr_low.push_back(nlow);
          fr_rise.push_back(nrise);
          fr_start.push_back(t_start);
          fr_end.push_back(cyc);
        end
        in_frame = 1'b0;
        if (dac_sclk) extra++;
      end
      p_cs   = dac_cs_n;
      p_sclk = dac_sclk;
      p_mosi = dac_mosi;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (fr_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(fr_data.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input int idx, input logic [11:0] exp, input string tag);
    if (idx < fr_data.size()) begin
      check({tag, "_data"}, 32'(fr_data[idx]), 32'(exp));
      check({tag, "_low"},  32'(fr_low[idx]),  32'(24 * DIV));
      check({tag, "_rise"}, 32'(fr_rise[idx]), 32'd12);
    end else begin
      check({tag, "_present"}, 32'(fr_data.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int base;
    int k;
    int nr;
    logic found;
    logic prev;

    // Reset state
    reset = 1'b1;
    #30;
    check("rst_cs_n",  32'(dac_cs_n),   32'd1);
    check("rst_sclk",  32'(dac_sclk),   32'd0);
    check("rst_mosi",  32'(dac_mosi),   32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf",   32'(overflow),   32'd0);
    #71;
    reset = 1'b0;
    tick();

    // Single frame 0x2A5 with latency and first-sclk timing
    din = 10'h2A5;
    en  = 1'b1;
    tick();
    check("lat_t0_level", 32'(fifo_level), 32'd1);
    check("lat_t0_cs_n",  32'(dac_cs_n),   32'd1);
    tick();
    check("lat_t1_level", 32'(fifo_level), 32'd0);
    check("lat_t1_busy",  32'(busy),       32'd1);
    check("lat_t1_cs_n",  32'(dac_cs_n),   32'd1);
    tick();
    check("lat_t2_cs_n",  32'(dac_cs_n),   32'd0);
    check("lat_t2_mosi",  32'(dac_mosi),   32'd0);
    tick();
    check("sclk_pre",     32'(dac_sclk),   32'd0);
    tick();
    check("sclk_first",   32'(dac_sclk),   32'd1);
    wait_frames(1, 200, "frame_2a5_wait");
    check_frame(0, 12'h6A5, "frame_2a5");

    // Constant input sends exactly one frame
    din = 10'h155;
    repeat (200) tick();
    check("const_count", 32'(fr_data.size()), 32'd2);
    check_frame(1, 12'h555, "frame_155");
    check("const_level", 32'(fifo_level), 32'd0);
    check("const_busy",  32'(busy),       32'd0);

    // en=0 blocks capture and freezes last
    en  = 1'b0;
    din = 10'h222;
    repeat (3) tick();
    check("en0_level", 32'(fifo_level), 32'd0);
    check("en0_busy",  32'(busy),       32'd0);
    din = 10'h155;
    en  = 1'b1;
    tick();
    check("en0_hold_level", 32'(fifo_level), 32'd0);

    // Burst 1..8 into a depth-4 FIFO: 6..8 dropped, clear collides with a drop
    base = fr_data.size();
    for (int v = 1; v <= 5; v++) begin
      din = 10'(v);
      tick();
    end
    check("burst_full_level", 32'(fifo_level), 32'd4);
    check("burst_no_ovf",     32'(overflow),   32'd0);
    din = 10'd6;
    tick();
    check("burst_ovf_set",    32'(overflow),   32'd1);
    check("burst_drop_level", 32'(fifo_level), 32'd4);
    din = 10'd7;
    clr_ovf = 1'b1;
    tick();
    check("burst_clr_vs_drop", 32'(overflow), 32'd1);
    clr_ovf = 1'b0;
    din = 10'd8;
    tick();
    wait_frames(base + 5, 600, "burst_wait");
    for (int i = 0; i < 5; i++) check_frame(base + i, 12'h400 | 12'(i + 1), $sformatf("burst_f%0d", i));
    for (int i = 0; i < 4; i++) begin
      if (base + i + 1 < fr_data.size())
        check($sformatf("burst_gap%0d", i), 32'(fr_start[base + i + 1] - fr_end[base + i]), 32'(2 * DIV + 2));
    end
    repeat (50) tick();
    check("burst_count",  32'(fr_data.size()), 32'(base + 5));
    check("burst_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("burst_ovf_clr", 32'(overflow), 32'd0);

    // Push and pop in the same cycle while full
    base = fr_data.size();
    for (int v = 0; v < 5; v++) begin
      din = 10'h100 + 10'(v);
      tick();
    end
    check("pp_full_level", 32'(fifo_level), 32'd4);
    found = 1'b0;
    k = 0;
    while (!found && k < 200) begin
      if (busy == 1'b0 && fifo_level == 3'd4) found = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    check("pp_idle_full_found", 32'(found), 32'd1);
    din = 10'h105;
    tick();
    check("pp_level_same", 32'(fifo_level), 32'd4);
    check("pp_no_ovf",     32'(overflow),   32'd0);
    wait_frames(base + 6, 800, "pp_wait");
    for (int i = 0; i < 6; i++) check_frame(base + i, 12'h500 + 12'(i), $sformatf("pp_f%0d", i));

    // Reset at the 6th rising sclk edge of a frame, with one sample still queued
    base = fr_data.size();
    din = 10'h0AA;
    tick();
    din = 10'h3FF;
    tick();
    en = 1'b0;
    nr = 0;
    k = 0;
    prev = dac_sclk;
    while (nr < 6 && k < 100) begin
      tick();
      k++;
      if (dac_sclk && !prev) nr++;
      prev = dac_sclk;
    end
    check("abort_rise6", 32'(nr), 32'd6);
    reset = 1'b1;
    #1;
    check("abort_cs_n",  32'(dac_cs_n),   32'd1);
    check("abort_sclk",  32'(dac_sclk),   32'd0);
    check("abort_mosi",  32'(dac_mosi),   32'd0);
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_busy",  32'(busy),       32'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (100) tick();
    check("abort_no_frame", 32'(fr_data.size()), 32'(base));
    check("abort_level2",   32'(fifo_level),     32'd0);
    en = 1'b1;
    tick();
    check("post_rst_capture", 32'(fifo_level), 32'd1);
    wait_frames(base + 1, 200, "post_rst_wait");
    check_frame(base, 12'h7FF, "post_rst_3ff");
    repeat (150) tick();
    check("post_rst_count", 32'(fr_data.size()), 32'(base + 1));

    // Whole-run pin discipline
    check("mosi_only_on_fall", 32'(viol),  32'd0);
    check("sclk_low_when_idle", 32'(extra), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
